// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//     - state_e    : FSM state encoding (IDLE, SHIFT, DONE)
//     - cnt_width(): bit counter width for a given operand width,
//                    never less than one bit so WIDTH=1 still has a counter
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/bit_sub_cell.sv
// bit_sub_cell
//   Combinational 1-bit full subtractor: computes a - b - bin for one bit.
//   Ports:
//     a, b  in   operand bits (minuend, subtrahend)
//     bin   in   borrow into this bit
//     d     out  difference bit
//     bout  out  borrow out of this bit
module bit_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // A borrow leaves this bit when b exceeds a outright, or when a and b
    // are equal and a borrow was already pending from below.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - bin (modulo 2^WIDTH), one bit per
//   clock, LSB first, using a single bit_sub_cell. A start/done handshake
//   controls it; the result is valid with done and held until the next
//   accepted start.
//
//   Parameters:
//     WIDTH       operand/result width (>= 1)
//   Ports:
//     clk         clock, rising edge
//     rst         synchronous active-high reset
//     start       request; accepted only in IDLE or DONE
//     a, b, bin   minuend, subtrahend, initial borrow (captured on accept)
//     busy        high while bits are being processed
//     done        one-cycle pulse when diff/borrow_out become valid
//     diff        result, held from done until the next accepted start
//     borrow_out  final unsigned borrow (a < b + bin)
//     overflow    signed overflow flag, present only when the macro
//                 SERIAL_SUB_OVF_EN is defined
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             overflow
`endif
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic               brw_q, brw_d;
    logic               borrow_out_q, borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
    logic               msb_brw_q, msb_brw_d;
`endif

    logic               accept;
    logic               cell_d;
    logic               cell_bout;

    bit_sub_cell u_cell (
        .a    (a_sr_q[0]),
        .b    (b_sr_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        a_sr_d       = a_sr_q;
        b_sr_d       = b_sr_q;
        res_d        = res_q;
        brw_d        = brw_q;
        borrow_out_d = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
        msb_brw_d    = msb_brw_q;
`endif

        if (accept) begin
            // Result register is left alone here so the previous answer
            // stays visible until the first bit of the new one lands.
            state_d = ST_SHIFT;
            a_sr_d  = a;
            b_sr_d  = b;
            brw_d   = bin;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_SHIFT: begin
                    a_sr_d = a_sr_q >> 1;
                    b_sr_d = b_sr_q >> 1;
                    brw_d  = cell_bout;
                    cnt_d  = cnt_q + CNT_W'(1);
                    // First bit of an operation drops the stale result;
                    // later bits shift it down and enter at the MSB.
                    if (cnt_q == '0) begin
                        res_d = '0;
                    end else begin
                        res_d = res_q >> 1;
                    end
                    res_d[WIDTH-1] = cell_d;
                    if (cnt_q == CNT_LAST) begin
                        state_d      = ST_DONE;
                        cnt_d        = '0;
                        borrow_out_d = cell_bout;
`ifdef SERIAL_SUB_OVF_EN
                        msb_brw_d    = brw_q;
`endif
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            a_sr_q       <= '0;
            b_sr_q       <= '0;
            res_q        <= '0;
            brw_q        <= 1'b0;
            borrow_out_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            msb_brw_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            a_sr_q       <= a_sr_d;
            b_sr_q       <= b_sr_d;
            res_q        <= res_d;
            brw_q        <= brw_d;
            borrow_out_q <= borrow_out_d;
`ifdef SERIAL_SUB_OVF_EN
            msb_brw_q    <= msb_brw_d;
`endif
        end
    end

    assign busy       = (state_q == ST_SHIFT);
    assign done       = (state_q == ST_DONE);
    assign diff       = res_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUB_OVF_EN
    // Signed overflow: borrow into the sign bit differs from borrow out of it.
    assign overflow   = msb_brw_q ^ borrow_out_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8 main instance plus a
//   WIDTH=1 instance). A behavioural model computes results with plain
//   integer arithmetic and tracks the handshake timing; one compare process
//   checks the DUT against it every cycle, and directed operations pin the
//   model with hand-computed literals. Overflow is checked when
//   SERIAL_SUB_OVF_EN is defined.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    wire          busy;
    wire          done;
    wire  [W-1:0] diff;
    wire          borrowOut;
`ifdef SERIAL_SUB_OVF_EN
    wire          overflow;
    wire          overflow1;
`endif

    logic start1;
    logic a1;
    logic b1;
    logic bin1;
    wire  busy1;
    wire  done1;
    wire  diff1;
    wire  borrowOut1;

    int total = 0;
    int bad   = 0;

    serial_subtractor #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrowOut)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow)
`endif
    );

    serial_subtractor #(.WIDTH(1)) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start1),
        .a          (a1),
        .b          (b1),
        .bin        (bin1),
        .busy       (busy1),
        .done       (done1),
        .diff       (diff1),
        .borrow_out (borrowOut1)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .overflow   (overflow1)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an accepted request keeps the unit busy for W
    // cycles, then the result of plain integer subtraction is shown with a
    // one-cycle done and held afterwards.
    int           mRemain = 0;
    logic         mDone   = 1'b0;
    logic [W-1:0] mDiff   = '0;
    logic         mBorrow = 1'b0;
    logic [W-1:0] pDiff;
    logic         pBorrow;
    bit           modelLive = 1'b0;
    int           full;
`ifdef SERIAL_SUB_OVF_EN
    logic         mOvf = 1'b0;
    logic         pOvf;
    int           sa;
    int           sb;
    int           sfull;
`endif

    always @(posedge clk) begin
        if (rst) begin
            mRemain = 0;
            mDone   = 1'b0;
            mDiff   = '0;
            mBorrow = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            mOvf    = 1'b0;
`endif
        end else begin
            mDone = 1'b0;
            if (mRemain > 0) begin
                mRemain--;
                if (mRemain == 0) begin
                    mDone   = 1'b1;
                    mDiff   = pDiff;
                    mBorrow = pBorrow;
`ifdef SERIAL_SUB_OVF_EN
                    mOvf    = pOvf;
`endif
                end
            end else if (start === 1'b1) begin
                full    = int'(a) - int'(b) - int'(bin);
                pDiff   = W'(full);
                pBorrow = (full < 0);
`ifdef SERIAL_SUB_OVF_EN
                sa      = $signed(a);
                sb      = $signed(b);
                sfull   = sa - sb - int'(bin);
                pOvf    = (sfull < -128) || (sfull > 127);
`endif
                mRemain = W;
            end
        end
        modelLive = 1'b1;
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("busy", busy, mRemain > 0);
            checkOutput("done", done, mDone);
            checkOutput("busy_done_overlap", busy & done, 1'b0);
            if (mRemain == 0) begin
                checkOutput("diff", diff, mDiff);
                checkOutput("borrow_out", borrowOut, mBorrow);
`ifdef SERIAL_SUB_OVF_EN
                checkOutput("overflow", overflow, mOvf);
`endif
            end
        end
    end

    task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ibin);
        @(negedge clk);
        a     = ia;
        b     = ib;
        bin   = ibin;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("[TB] FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    task automatic runOp(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic ibin, input logic [W-1:0] expDiff, input logic expBorrow);
        bit ok;
        applyStimulus(ia, ib, ibin);
        waitDone(ok);
        if (ok) begin
            checkOutput({name, "_diff"}, diff, expDiff);
            checkOutput({name, "_borrow"}, borrowOut, expBorrow);
        end
    endtask

    task automatic runOp1(input string name, input logic ia, input logic ib, input logic ibin,
                          input logic expDiff, input logic expBorrow);
        @(negedge clk);
        a1     = ia;
        b1     = ib;
        bin1   = ibin;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        checkOutput({name, "_busy"}, busy1, 1'b1);
        checkOutput({name, "_done_early"}, done1, 1'b0);
        @(negedge clk);
        checkOutput({name, "_done"}, done1, 1'b1);
        checkOutput({name, "_busy_off"}, busy1, 1'b0);
        checkOutput({name, "_diff"}, diff1, expDiff);
        checkOutput({name, "_borrow"}, borrowOut1, expBorrow);
    endtask

    initial begin
        bit ok;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        bin    = 1'b0;
        start1 = 1'b0;
        a1     = 1'b0;
        b1     = 1'b0;
        bin1   = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 1'b0);
        checkOutput("reset_done", done, 1'b0);
        checkOutput("reset_diff", diff, 8'h00);
        checkOutput("reset_borrow", borrowOut, 1'b0);
        rst = 1'b0;

        runOp("op_35_12", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0);
        @(negedge clk);
        checkOutput("done_one_cycle", done, 1'b0);
        checkOutput("diff_held", diff, 8'h23);
        runOp("op_12_35", 8'h12, 8'h35, 1'b0, 8'hDD, 1'b1);
        runOp("op_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);

        // A second start at SHIFT cycle 3 must not disturb the running op.
        applyStimulus(8'h10, 8'h10, 1'b1);
        repeat (2) @(negedge clk);
        a     = 8'h55;
        b     = 8'h11;
        bin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(ok);
        if (ok) begin
            checkOutput("ignored_start_diff", diff, 8'hFF);
            checkOutput("ignored_start_borrow", borrowOut, 1'b1);
        end
        @(negedge clk);
        checkOutput("ignored_start_idle", busy, 1'b0);

        // start held high through DONE chains straight into the next op.
        @(negedge clk);
        a     = 8'h40;
        b     = 8'h01;
        bin   = 1'b0;
        start = 1'b1;
        waitDone(ok);
        if (ok) begin
            checkOutput("chain_first_diff", diff, 8'h3F);
        end
        a = 8'h02;
        b = 8'h03;
        @(negedge clk);
        checkOutput("chain_no_idle_gap", busy, 1'b1);
        start = 1'b0;
        waitDone(ok);
        if (ok) begin
            checkOutput("chain_second_diff", diff, 8'hFF);
            checkOutput("chain_second_borrow", borrowOut, 1'b1);
        end

        // Reset in the middle of SHIFT aborts the operation.
        applyStimulus(8'h77, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_busy", busy, 1'b0);
        checkOutput("midreset_done", done, 1'b0);
        checkOutput("midreset_diff", diff, 8'h00);
        checkOutput("midreset_borrow", borrowOut, 1'b0);
        rst = 1'b0;
        runOp("op_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
        runOp("ovf_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0);
        checkOutput("ovf_80_01_flag", overflow, 1'b1);
        runOp("ovf_7f_01", 8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0);
        checkOutput("ovf_7f_01_flag", overflow, 1'b0);
`endif

        runOp1("w1_0_1_0", 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        runOp1("w1_1_1_1", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        runOp1("w1_1_0_0", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

        // Random traffic: requests arrive at random, including while busy,
        // with an occasional reset.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom_range(0, 1));
            rst   = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        repeat (12) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
